// File: rtl/reorder_buffer_pkg.sv
// Shared LC-3b datapath types used by the reorder buffer and its neighbours.
// Latency: n/a (types only). Backpressure: n/a.
package lc3b_types;

  typedef logic [2:0]  lc3b_rob_addr;
  typedef logic [2:0]  lc3b_reg;
  typedef logic [15:0] lc3b_word;

  typedef enum logic [3:0] {
    op_br   = 4'd0,
    op_add  = 4'd1,
    op_ldb  = 4'd2,
    op_stb  = 4'd3,
    op_jsr  = 4'd4,
    op_and  = 4'd5,
    op_ldr  = 4'd6,
    op_str  = 4'd7,
    op_rti  = 4'd8,
    op_not  = 4'd9,
    op_ldi  = 4'd10,
    op_sti  = 4'd11,
    op_jmp  = 4'd12,
    op_shf  = 4'd13,
    op_lea  = 4'd14,
    op_trap = 4'd15
  } lc3b_opcode;

  typedef struct packed {
    logic       busy;
    logic       ready;
    lc3b_opcode opcode;
    lc3b_reg    dest;
    lc3b_word   pc;
    logic       predict;
    lc3b_word   value;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_rob_ptr.sv
// Wrapping circular-buffer pointer with clear (priority) and increment.
// Latency: 1 cycle from inc/clr to new pointer value. Backpressure: none, caller gates inc.
module rob_ptr #(
  parameter int width = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [width-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocate at tail, complete from CDB, retire from head.
// Latency: allocate/CDB/retire visible at head next cycle; read ports forward CDB same cycle.
// Backpressure: full blocks allocate unless the head retires in the same cycle.
module reorder_buffer
  import lc3b_types::*;
#(
  parameter int data_width = 16,
  parameter int tag_width  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  alloc_we,
  input  lc3b_opcode            alloc_opcode,
  input  lc3b_reg               alloc_dest,
  input  lc3b_word              alloc_pc,
  input  logic                  alloc_predict,
  input  logic                  alloc_ready,
  input  logic [data_width-1:0] alloc_value,
  output logic [tag_width-1:0]  alloc_addr,
  output logic                  full,
  input  logic                  cdb_valid,
  input  logic [tag_width-1:0]  cdb_tag,
  input  logic [data_width-1:0] cdb_value,
  input  logic [tag_width-1:0]  rd_tag_a,
  input  logic [tag_width-1:0]  rd_tag_b,
  output logic [data_width-1:0] rd_value_a,
  output logic [data_width-1:0] rd_value_b,
  output logic                  rd_ready_a,
  output logic                  rd_ready_b,
  input  logic                  RE,
  output logic                  valid_out,
  output lc3b_opcode            opcode_out,
  output lc3b_reg               dest_out,
  output logic [data_width-1:0] value_out,
  output logic                  predict_out,
  output lc3b_word              pc_out,
  output logic [tag_width-1:0]  rob_addr,
  output logic                  empty
);

  localparam int depth = 2 ** tag_width;

  rob_entry_t           entries_q [depth];
  rob_entry_t           head_entry;
  rob_entry_t           alloc_entry;
  logic [tag_width:0]   count_q;
  logic [tag_width-1:0] head;
  logic [tag_width-1:0] tail;
  logic                 head_valid;
  logic                 do_retire;
  logic                 do_alloc;
  logic                 cdb_hit;

  assign head_entry = entries_q[head];
  assign empty      = (count_q == '0);
  assign full       = (count_q == (tag_width + 1)'(depth));
  assign head_valid = !empty && head_entry.busy && head_entry.ready;

  // Flush outranks every other update; a retiring head frees its slot for a same-cycle allocate.
  assign do_retire = RE && head_valid && !flush;
  assign do_alloc  = alloc_we && (!full || do_retire) && !flush;
  assign cdb_hit   = cdb_valid && entries_q[cdb_tag].busy && !flush;

  rob_ptr #(.width(tag_width)) u_head_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (do_retire),
    .ptr   (head)
  );

  rob_ptr #(.width(tag_width)) u_tail_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (do_alloc),
    .ptr   (tail)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else if (do_alloc && !do_retire) begin
      count_q <= count_q + 1'b1;
    end else if (do_retire && !do_alloc) begin
      count_q <= count_q - 1'b1;
    end
  end

  always_comb begin
    alloc_entry         = '0;
    alloc_entry.busy    = 1'b1;
    alloc_entry.ready   = alloc_ready;
    alloc_entry.opcode  = alloc_opcode;
    alloc_entry.dest    = alloc_dest;
    alloc_entry.pc      = alloc_pc;
    alloc_entry.predict = alloc_predict;
    alloc_entry.value   = alloc_ready ? alloc_value : '0;
  end

  // Later assignments win: allocate overrides a CDB hit on the same slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < depth; i++) begin
        entries_q[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < depth; i++) begin
        entries_q[i].busy  <= 1'b0;
        entries_q[i].ready <= 1'b0;
      end
    end else begin
      if (cdb_hit) begin
        entries_q[cdb_tag].value <= cdb_value;
        entries_q[cdb_tag].ready <= 1'b1;
      end
      if (do_retire) begin
        entries_q[head].busy  <= 1'b0;
        entries_q[head].ready <= 1'b0;
      end
      if (do_alloc) begin
        entries_q[tail] <= alloc_entry;
      end
    end
  end

  always_comb begin
    rd_value_a = entries_q[rd_tag_a].value;
    rd_ready_a = entries_q[rd_tag_a].busy && entries_q[rd_tag_a].ready;
    if (cdb_valid && (cdb_tag == rd_tag_a) && entries_q[rd_tag_a].busy) begin
      rd_value_a = cdb_value;
      rd_ready_a = 1'b1;
    end
  end

  always_comb begin
    rd_value_b = entries_q[rd_tag_b].value;
    rd_ready_b = entries_q[rd_tag_b].busy && entries_q[rd_tag_b].ready;
    if (cdb_valid && (cdb_tag == rd_tag_b) && entries_q[rd_tag_b].busy) begin
      rd_value_b = cdb_value;
      rd_ready_b = 1'b1;
    end
  end

  assign valid_out   = head_valid;
  assign opcode_out  = head_entry.opcode;
  assign dest_out    = head_entry.dest;
  assign value_out   = head_entry.value;
  assign predict_out = head_entry.predict;
  assign pc_out      = head_entry.pc;
  assign rob_addr    = head;
  assign alloc_addr  = tail;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed and random checks of reorder_buffer against a queue-based program-order model.
module tb_reorder_buffer;
  import lc3b_types::*;

  localparam int DW    = 16;
  localparam int TW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n, flush, alloc_we, alloc_predict, alloc_ready;
  lc3b_opcode    alloc_opcode, opcode_out;
  lc3b_reg       alloc_dest, dest_out;
  lc3b_word      alloc_pc, pc_out;
  logic [DW-1:0] alloc_value, cdb_value, rd_value_a, rd_value_b, value_out;
  logic [TW-1:0] alloc_addr, cdb_tag, rd_tag_a, rd_tag_b, rob_addr;
  logic          full, cdb_valid, rd_ready_a, rd_ready_b, RE, valid_out, predict_out, empty;

  reorder_buffer #(.data_width(DW), .tag_width(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .alloc_we(alloc_we),
    .alloc_opcode(alloc_opcode), .alloc_dest(alloc_dest), .alloc_pc(alloc_pc),
    .alloc_predict(alloc_predict), .alloc_ready(alloc_ready), .alloc_value(alloc_value),
    .alloc_addr(alloc_addr), .full(full), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .rd_tag_a(rd_tag_a), .rd_tag_b(rd_tag_b),
    .rd_value_a(rd_value_a), .rd_value_b(rd_value_b), .rd_ready_a(rd_ready_a),
    .rd_ready_b(rd_ready_b), .RE(RE), .valid_out(valid_out), .opcode_out(opcode_out),
    .dest_out(dest_out), .value_out(value_out), .predict_out(predict_out),
    .pc_out(pc_out), .rob_addr(rob_addr), .empty(empty)
  );

  always #5 clk = ~clk;

  // Model: q holds in-flight slot indices in program order; per-slot field arrays.
  int            q[$];
  int            m_head, m_tail;
  logic          m_ready [DEPTH];
  logic [DW-1:0] m_val   [DEPTH];
  logic [3:0]    m_op    [DEPTH];
  logic [2:0]    m_dest  [DEPTH];
  logic [15:0]   m_pc    [DEPTH];
  logic          m_pred  [DEPTH];
  int            n_assert = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_flight(input int t);
    foreach (q[i]) if (q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] exp_rd_val(input int t);
    if (cdb_valid && int'(cdb_tag) == t && in_flight(t)) return cdb_value;
    return m_val[t];
  endfunction

  function automatic bit exp_rd_rdy(input int t);
    return in_flight(t) && (m_ready[t] || (cdb_valid && int'(cdb_tag) == t));
  endfunction

  task automatic check_all(input bit hv);
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("alloc_addr", 32'(alloc_addr), 32'(m_tail));
    chk("rob_addr", 32'(rob_addr), 32'(m_head));
    chk("valid_out", 32'(valid_out), 32'(hv));
    if (hv) begin
      chk("opcode_out", 32'(opcode_out), 32'(m_op[m_head]));
      chk("dest_out", 32'(dest_out), 32'(m_dest[m_head]));
      chk("value_out", 32'(value_out), 32'(m_val[m_head]));
      chk("predict_out", 32'(predict_out), 32'(m_pred[m_head]));
      chk("pc_out", 32'(pc_out), 32'(m_pc[m_head]));
    end
    chk("rd_value_a", 32'(rd_value_a), 32'(exp_rd_val(int'(rd_tag_a))));
    chk("rd_ready_a", 32'(rd_ready_a), 32'(exp_rd_rdy(int'(rd_tag_a))));
    chk("rd_value_b", 32'(rd_value_b), 32'(exp_rd_val(int'(rd_tag_b))));
    chk("rd_ready_b", 32'(rd_ready_b), 32'(exp_rd_rdy(int'(rd_tag_b))));
  endtask

  // Inputs are set just after a rising edge; check mid-cycle, then advance the model at the edge.
  task automatic step(input bit do_check);
    bit hv, retire, alloc, cdb_ok;
    #3;
    hv     = (q.size() > 0) && m_ready[m_head];
    if (do_check) check_all(hv);
    retire = RE && hv;
    alloc  = alloc_we && (q.size() < DEPTH || retire);
    cdb_ok = cdb_valid && in_flight(int'(cdb_tag));
    @(posedge clk);
    if (!rst_n) begin
      q.delete(); m_head = 0; m_tail = 0;
      for (int i = 0; i < DEPTH; i++) begin
        m_ready[i] = 0; m_val[i] = '0; m_op[i] = '0; m_dest[i] = '0; m_pc[i] = '0; m_pred[i] = 0;
      end
    end else if (flush) begin
      q.delete(); m_head = 0; m_tail = 0;
      for (int i = 0; i < DEPTH; i++) m_ready[i] = 0;
    end else begin
      if (cdb_ok) begin
        m_val[cdb_tag] = cdb_value; m_ready[cdb_tag] = 1;
      end
      if (retire) begin
        void'(q.pop_front()); m_ready[m_head] = 0; m_head = (m_head + 1) % DEPTH;
      end
      if (alloc) begin
        m_op[m_tail] = alloc_opcode; m_dest[m_tail] = alloc_dest; m_pc[m_tail] = alloc_pc;
        m_pred[m_tail] = alloc_predict; m_ready[m_tail] = alloc_ready;
        m_val[m_tail] = alloc_ready ? alloc_value : '0;
        q.push_back(m_tail); m_tail = (m_tail + 1) % DEPTH;
      end
    end
    #1;
  endtask

  task automatic set_alloc(input bit we, input bit rdy);
    alloc_we      = we;
    alloc_opcode  = lc3b_opcode'($urandom_range(0, 15));
    alloc_dest    = 3'($urandom_range(0, 7));
    alloc_pc      = 16'($urandom);
    alloc_predict = 1'($urandom_range(0, 1));
    alloc_ready   = rdy;
    alloc_value   = 16'($urandom);
  endtask

  task automatic idle();
    flush = 0; RE = 0; cdb_valid = 0; cdb_tag = '0; cdb_value = '0;
    rd_tag_a = '0; rd_tag_b = '0;
    set_alloc(0, 0);
  endtask

  initial begin
    idle();
    rst_n = 0;
    step(0);
    step(0);
    rst_n = 1;
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_alloc_addr", 32'(alloc_addr), 32'd0);
    chk("rst_rob_addr", 32'(rob_addr), 32'd0);
    chk("rst_value_out", 32'(value_out), 32'd0);
    chk("rst_pc_out", 32'(pc_out), 32'd0);
    chk("rst_rd_value_a", 32'(rd_value_a), 32'd0);

    // Fill with eight ADDs that are not yet complete.
    for (int i = 0; i < DEPTH; i++) begin
      set_alloc(1, 0); alloc_opcode = op_add;
      chk("fill_tag", 32'(alloc_addr), 32'(i));
      step(1);
    end
    chk("fill_full", 32'(full), 32'd1);
    step(1);
    chk("overfill_tail", 32'(alloc_addr), 32'd0);
    chk("overfill_full", 32'(full), 32'd1);
    idle();

    cdb_valid = 1; cdb_tag = 3'd0; cdb_value = 16'h1234;
    step(1);
    idle();
    chk("cdb_valid_out", 32'(valid_out), 32'd1);
    chk("cdb_value_out", 32'(value_out), 32'h1234);
    RE = 1;
    step(1);
    idle();
    chk("retire_rob_addr", 32'(rob_addr), 32'd1);
    chk("retire_empty", 32'(empty), 32'd0);

    // Refill to eight while completing the head, then allocate and retire together.
    set_alloc(1, 0); cdb_valid = 1; cdb_tag = 3'd1; cdb_value = 16'h0bad;
    step(1);
    idle();
    set_alloc(1, 0); RE = 1;
    step(1);
    idle();
    chk("both_full", 32'(full), 32'd1);
    chk("both_rob_addr", 32'(rob_addr), 32'd2);
    chk("both_alloc_addr", 32'(alloc_addr), 32'd2);

    cdb_valid = 1; cdb_tag = 3'd3; cdb_value = 16'hbeef; rd_tag_a = 3'd3;
    #1;
    chk("fwd_value", 32'(rd_value_a), 32'hbeef);
    chk("fwd_ready", 32'(rd_ready_a), 32'd1);
    step(1);
    idle();
    for (int t = 0; t < DEPTH; t++) begin
      cdb_valid = 1; cdb_tag = TW'(t); cdb_value = 16'($urandom);
      step(1);
    end
    idle();
    RE = 1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_valid", 32'(valid_out), 32'd1);
      step(1);
    end
    idle();
    chk("drain_empty", 32'(empty), 32'd1);

    cdb_valid = 1; cdb_tag = 3'd5; cdb_value = 16'h5555; rd_tag_a = 3'd5;
    #1;
    chk("cdb_nonbusy_rdy", 32'(rd_ready_a), 32'd0);
    step(1);
    idle();
    chk("cdb_nonbusy_valid", 32'(valid_out), 32'd0);
    chk("cdb_nonbusy_empty", 32'(empty), 32'd1);

    for (int i = 0; i < 5; i++) begin
      set_alloc(1, 1'($urandom_range(0, 1)));
      step(1);
    end
    set_alloc(1, 1); flush = 1; RE = 1; cdb_valid = 1; cdb_tag = 3'd3;
    step(1);
    idle();
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_alloc_addr", 32'(alloc_addr), 32'd0);
    chk("flush_valid", 32'(valid_out), 32'd0);
    chk("flush_rob_addr", 32'(rob_addr), 32'd0);

    // Completed-at-allocation fill from slot 0, drained back-to-back across the wrap.
    for (int i = 0; i < DEPTH; i++) begin
      set_alloc(1, 1);
      step(1);
    end
    idle();
    RE = 1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("wrap_valid", 32'(valid_out), 32'd1);
      chk("wrap_rob_addr", 32'(rob_addr), 32'(i));
      step(1);
    end
    idle();
    chk("wrap_empty", 32'(empty), 32'd1);
    chk("wrap_head", 32'(rob_addr), 32'd0);
    chk("wrap_next_tag", 32'(alloc_addr), 32'd0);
    set_alloc(1, 1);
    step(1);
    step(1);
    step(1);
    rst_n = 0;
    step(1);
    rst_n = 1;
    idle();
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_alloc_addr", 32'(alloc_addr), 32'd0);
    chk("midrst_valid", 32'(valid_out), 32'd0);
    chk("midrst_value_out", 32'(value_out), 32'd0);

    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      flush = ($urandom_range(0, 49) == 0);
      set_alloc($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)));
      RE = 1'($urandom_range(0, 1));
      cdb_valid = ($urandom_range(0, 9) < 6);
      cdb_value = 16'($urandom);
      if (q.size() > 0 && $urandom_range(0, 4) != 0)
        cdb_tag = TW'(q[$urandom_range(0, q.size() - 1)]);
      else
        cdb_tag = TW'($urandom_range(0, DEPTH - 1));
      rd_tag_a = ($urandom_range(0, 2) == 0) ? cdb_tag : TW'($urandom_range(0, DEPTH - 1));
      rd_tag_b = TW'($urandom_range(0, DEPTH - 1));
      step(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular reorder buffer that holds in-flight instructions in program order between issue and commit. Decode/issue allocates entries at the tail, the common data bus (CDB) marks entries complete, and the head entry is presented to the write-results/commit control, which retires it with a read-enable. A flush from commit discards every entry.

## Interface
Parameters:
- data_width, 16, width of result value
- tag_width, 3, ROB index width; depth = 2**tag_width (8)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; synchronous, active-low
- flush  in  1  discard all entries (from commit)
- alloc_we  in  1  allocate one entry at tail
- alloc_opcode  in  lc3b_opcode  opcode of allocated instruction
- alloc_dest  in  lc3b_reg  destination register, or branch nzp in its low 3 bits
- alloc_pc  in  lc3b_word  instruction PC
- alloc_predict  in  1  branch/jsr prediction bit
- alloc_ready  in  1  entry is complete at allocation
- alloc_value  in  data_width  initial value, used when alloc_ready=1
- alloc_addr  out  tag_width  current tail index; tag handed to reservation stations
- full  out  1  count == depth
- cdb_valid  in  1  broadcast valid
- cdb_tag  in  tag_width  ROB index being completed
- cdb_value  in  data_width  result value
- rd_tag_a, rd_tag_b  in  tag_width  operand lookup tags
- rd_value_a, rd_value_b  out  data_width  value of looked-up entry
- rd_ready_a, rd_ready_b  out  1  looked-up entry is busy and complete
- RE  in  1  retire head (from commit)
- valid_out  out  1  head is busy and complete
- opcode_out, dest_out, value_out, predict_out, pc_out  out  per field  head entry contents
- rob_addr  out  tag_width  head index
- empty  out  1  count == 0

## Operation
- Per-entry state: busy, ready, opcode, dest, pc, predict, value.
- Pointers: head and tail, each tag_width bits, wrapping modulo depth. Count is tag_width+1 bits, 0..depth.
- Allocate when alloc_we && !full:
  - write fields at tail; set busy=1, ready=alloc_ready;
  - value=alloc_value if alloc_ready, else 0;
  - tail+1.
  - alloc_we while full is ignored with no state change.
- CDB when cdb_valid && busy[cdb_tag]: value=cdb_value, ready=1. A CDB hit on a non-busy entry is ignored.
- Retire when RE && valid_out: busy=0, ready=0, head+1. RE while head is not valid is ignored.
- Count changes by +1 on allocate only, −1 on retire only, and stays put when both occur in the same cycle. Allocate and retire together are legal when full (retire frees the slot the same cycle only if the head is valid).
- Flush: clear all busy/ready bits; head=tail=count=0. Flush has priority over allocate, CDB and RE in the same cycle.
- CDB and allocate on the same index in the same cycle: allocate wins, and the entry takes the allocate fields.
- Read ports are combinational from the array, with same-cycle CDB forwarding: if cdb_valid && cdb_tag==rd_tag && busy, output cdb_value with ready=1.
- Head outputs are combinational from the head entry. Fields are don't-care when empty; valid_out is forced to 0 when empty.

## Timing
- Reset (rst_n=0 at a clk edge): all busy/ready bits, head, tail and count = 0.
  - Outputs after reset: empty=1, full=0, valid_out=0, alloc_addr=0, rob_addr=0.
  - Head fields and read values are 0.
- An allocated entry is visible at the head the next cycle. valid_out=1 that cycle if alloc_ready=1.
- A CDB write is reflected in valid_out and value_out the next cycle; read ports see it the same cycle.
- Retire takes effect at the clock edge. The new head is presented in the following cycle, so back-to-back retire at 1 per cycle is allowed.
- full and empty are registered-count decodes and are valid every cycle. alloc_addr is stable until an allocate or flush edge.
- Reset or flush mid-operation drops in-flight entries without emitting valid_out.

## Structure
- The following typedefs live in lc3b_types: lc3b_rob_addr (tag_width), lc3b_opcode, lc3b_reg, lc3b_word, and a new packed struct rob_entry_t (busy, ready, opcode, dest, pc, predict, value).
- One sub-module, rob_ptr: a wrapping tag_width pointer register with inc and clr inputs, instantiated twice (head and tail).

## Test plan
- Reset, then allocate 8 ADDs with alloc_ready=0 → tags 0..7, full=1 after the 8th; a 9th alloc_we leaves tail and count unchanged.
- CDB tag 0 with value 0x1234 → next cycle valid_out=1, value_out=0x1234; RE → rob_addr=1, empty=0.
- Fill, complete all entries, then retire 8 with RE held high → valid_out each cycle, empty=1 after the last; head wraps 7→0 and the next allocate gets tag 0.
- Same-cycle allocate and RE with count=8 and head valid → count stays 8, tail and head both advance.
- cdb_tag=3 with cdb_valid in the same cycle as rd_tag_a=3 (busy) → rd_value_a=cdb_value, rd_ready_a=1 combinationally; CDB to a non-busy tag → no change.
- flush asserted together with alloc_we, RE and cdb_valid at count=5 → next cycle empty=1, alloc_addr=0, valid_out=0; rst_n low mid-fill gives the same result.
